// File: rtl/lsu_apb_bridge.sv
// Bridges single-outstanding LSU load/store requests onto an APB master port.
// Optional ACCESS-phase timeout compiled in with macro LSU_APB_BRIDGE_TIMEOUT_EN.
module lsu_apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Pclk,
    input  logic        Prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Paddr,
    output logic        Pwrite,
    output logic        Psel,
    output logic        Penable,
    output logic [31:0] Pwdata,
    output logic [3:0]  Pstrb,
    input  logic [31:0] Prdata,
    input  logic        Pready,
    input  logic        Pslverr
);

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        req_ready_d, psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
    logic [31:0] paddr_d, pwdata_d, rsp_rdata_d;
    logic [3:0]  pstrb_d;

`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;

    // This stalled ACCESS cycle is the TIMEOUT_CYCLES-th in a row
    assign tmo_hit = (32'(tmo_cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-output values; every register holds by default
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready;
        psel_d      = Psel;
        penable_d   = Penable;
        paddr_d     = Paddr;
        pwrite_d    = Pwrite;
        pwdata_d    = Pwdata;
        pstrb_d     = Pstrb;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pwdata_d    = req_write ? req_wdata : 32'd0;
                    pstrb_d     = req_write ? req_wstrb : 4'd0;
`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (Pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = Pwrite ? 32'd0 : Prdata;
                    rsp_err_d   = Pslverr;
`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
                    tmo_cnt_d   = '0;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = TIMEOUT_DATA;
                    rsp_err_d   = 1'b1;
                    tmo_cnt_d   = '0;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            Psel      <= 1'b0;
            Penable   <= 1'b0;
            Paddr     <= 32'd0;
            Pwrite    <= 1'b0;
            Pwdata    <= 32'd0;
            Pstrb     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            Psel      <= psel_d;
            Penable   <= penable_d;
            Paddr     <= paddr_d;
            Pwrite    <= pwrite_d;
            Pwdata    <= pwdata_d;
            Pstrb     <= pstrb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`endif

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Self-checking bench for lsu_apb_bridge: directed scenarios plus randomized
// transfers against a transaction-level model of the bridge's rules.
module tb_lsu_apb_bridge;

    localparam int unsigned TMO = 4;
`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        Pclk, Prst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic        Pwrite, Psel, Penable, Pready, Pslverr;
    logic [3:0]  Pstrb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;
    always @(posedge Pclk) cyc <= cyc + 1;

    lsu_apb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .Pclk(Pclk), .Prst(Prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Paddr(Paddr), .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable),
        .Pwdata(Pwdata), .Pstrb(Pstrb), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    typedef struct {
        logic        rr_before, rr_setup, s_psel, s_pen, a_psel, a_pen;
        logic        stable, resp_ok, idle_after;
        logic [31:0] s_addr, s_wdata;
        logic        s_write;
        logic [3:0]  s_strb;
        int          lat;
        int          t_acc;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    // Transaction-level expectation from the bridge rules
    function automatic void model(input logic wr, input logic [31:0] wd, input logic [3:0] st,
                                  input int wait_cyc, input logic [31:0] rd, input logic se,
                                  output logic [31:0] ewd, output logic [3:0] est, output int elat,
                                  output logic [31:0] erd, output logic eerr);
        bit timed;
        timed = TMO_EN && (wait_cyc >= int'(TMO));
        ewd   = wr ? wd : 32'd0;
        est   = wr ? st : 4'd0;
        elat  = timed ? int'(TMO) + 1 : wait_cyc + 2;
        erd   = timed ? 32'hDEAD_BEEF : (wr ? 32'd0 : rd);
        eerr  = timed | se;
    endfunction

    // Drives one transfer as requester and APB slave; called and returns at a negedge
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input int wait_cyc, input logic [31:0] rd,
                        input logic se, input int hold, output obs_t o);
        logic [31:0] r0;
        logic        e0;
        o = '{default: '0};
        o.lat = -1;
        o.rr_before = req_ready;
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = st;
        Pready = 1'b0;
        @(posedge Pclk);
        @(negedge Pclk);
        o.t_acc = cyc;
        o.rr_setup = req_ready;
        o.s_psel = Psel; o.s_pen = Penable; o.s_addr = Paddr; o.s_write = Pwrite;
        o.s_wdata = Pwdata; o.s_strb = Pstrb;
        // Noise on inputs the bridge must ignore outside IDLE / ACCESS
        req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom; req_wstrb = 4'($urandom);
        Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
        @(posedge Pclk);
        o.stable = 1'b1;
        for (int k = 2; k <= 300; k++) begin
            @(negedge Pclk);
            if (rsp_valid === 1'b1) begin
                o.lat = k - 1;
                break;
            end
            if (k == 2) begin
                o.a_psel = Psel; o.a_pen = Penable;
            end
            if ({Psel, Penable, Paddr, Pwrite, Pwdata, Pstrb} !==
                {2'b11, o.s_addr, o.s_write, o.s_wdata, o.s_strb}) o.stable = 1'b0;
            Pready  = (k - 2 >= wait_cyc);
            Prdata  = Pready ? rd : $urandom;
            Pslverr = Pready ? se : 1'($urandom);
            @(posedge Pclk);
        end
        if (o.lat < 0) return;
        Pready = 1'($urandom); Prdata = $urandom; Pslverr = 1'($urandom);
        r0 = rsp_rdata; e0 = rsp_err;
        o.rdata = r0; o.err = e0;
        o.resp_ok = (Psel === 1'b0) && (Penable === 1'b0) && (req_ready === 1'b0);
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge Pclk);
            @(negedge Pclk);
            if (!(rsp_valid === 1'b1 && rsp_rdata === r0 && rsp_err === e0 &&
                  req_ready === 1'b0 && Psel === 1'b0)) o.resp_ok = 1'b0;
            Pready = 1'($urandom); Prdata = $urandom;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Pclk);
        @(negedge Pclk);
        o.idle_after = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (Psel === 1'b0);
        rsp_ready = 1'b0;
        Pready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Pclk);
        checks++;
        if ({Psel, Penable, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_held: got %b expected 000", {Psel, Penable, rsp_valid});
        end
        Prst = 1'b0;
        @(negedge Pclk);
        checks++;
        if ({req_ready, Psel, Penable, Paddr, Pwrite, Pwdata, Pstrb, rsp_valid, rsp_rdata, rsp_err} !==
            {1'b1, 2'b00, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rr=%b sel=%b en=%b addr=%h wr=%b wd=%h st=%h rv=%b rd=%h err=%b expected rr=1 rest 0",
                     req_ready, Psel, Penable, Paddr, Pwrite, Pwdata, Pstrb, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_store();
        obs_t o;
        xfer(32'h2000_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 0, o);
        checks++;
        if ({o.rr_before, o.s_psel, o.s_pen, o.rr_setup, o.a_psel, o.a_pen, o.stable, o.resp_ok, o.idle_after} !== 9'b110011111) begin
            errors++; $display("FAIL store_handshake: got %b expected 110011111",
                {o.rr_before, o.s_psel, o.s_pen, o.rr_setup, o.a_psel, o.a_pen, o.stable, o.resp_ok, o.idle_after});
        end
        checks++;
        if ({o.s_addr, o.s_write, o.s_wdata, o.s_strb} !== {32'h2000_0000, 1'b1, 32'h1234_5678, 4'hF}) begin
            errors++; $display("FAIL store_apb: got addr=%h wr=%b wd=%h st=%h expected 20000000 1 12345678 f",
                o.s_addr, o.s_write, o.s_wdata, o.s_strb);
        end
        checks++;
        if (o.lat !== 2) begin
            errors++; $display("FAIL store_latency: got %0d expected 2", o.lat);
        end
        checks++;
        if ({o.rdata, o.err} !== {32'd0, 1'b0}) begin
            errors++; $display("FAIL store_rsp: got rd=%h err=%b expected 00000000 0", o.rdata, o.err);
        end
    endtask

    task automatic test_load();
        obs_t o;
        xfer(32'h2000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 0, 32'hA5A5_A5A5, 1'b0, 0, o);
        checks++;
        if ({o.s_addr, o.s_write, o.s_wdata, o.s_strb} !== {32'h2000_0004, 1'b0, 32'd0, 4'h0}) begin
            errors++; $display("FAIL load_apb: got addr=%h wr=%b wd=%h st=%h expected 20000004 0 00000000 0",
                o.s_addr, o.s_write, o.s_wdata, o.s_strb);
        end
        checks++;
        if ({o.lat == 2, o.rdata, o.err} !== {1'b1, 32'hA5A5_A5A5, 1'b0}) begin
            errors++; $display("FAIL load_rsp: got lat=%0d rd=%h err=%b expected 2 a5a5a5a5 0", o.lat, o.rdata, o.err);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        xfer(32'h2000_0010, 1'b0, 32'd0, 4'd0, 3, 32'h0BAD_F00D, 1'b0, 0, o);
        checks++;
        if (o.stable !== 1'b1) begin
            errors++; $display("FAIL wait_stable: got %b expected 1", o.stable);
        end
        checks++;
        if ({o.lat == 5, o.rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL wait_rsp: got lat=%0d rd=%h expected 5 0badf00d", o.lat, o.rdata);
        end
    endtask

    task automatic test_rsp_stall();
        obs_t o;
        xfer(32'h2000_0020, 1'b0, 32'd0, 4'd0, 0, 32'h5566_7788, 1'b0, 5, o);
        checks++;
        if ({o.resp_ok, o.idle_after} !== 2'b11) begin
            errors++; $display("FAIL stall_hold: got resp_ok=%b idle_after=%b expected 1 1", o.resp_ok, o.idle_after);
        end
        checks++;
        if (o.rdata !== 32'h5566_7788) begin
            errors++; $display("FAIL stall_rdata: got %h expected 55667788", o.rdata);
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        xfer(32'h2000_0030, 1'b1, 32'hCAFE_0001, 4'h3, 1, 32'h0, 1'b1, 0, o);
        checks++;
        if ({o.lat == 3, o.rdata, o.err} !== {1'b1, 32'd0, 1'b1}) begin
            errors++; $display("FAIL slverr_rsp: got lat=%0d rd=%h err=%b expected 3 00000000 1", o.lat, o.rdata, o.err);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
`ifdef LSU_APB_BRIDGE_TIMEOUT_EN
        xfer(32'h2000_0040, 1'b0, 32'd0, 4'd0, 1000, 32'h1111_1111, 1'b0, 0, o);
        checks++;
        if ({o.lat == int'(TMO) + 1, o.rdata, o.err, o.idle_after} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL timeout_fire: got lat=%0d rd=%h err=%b idle=%b expected %0d deadbeef 1 1",
                o.lat, o.rdata, o.err, o.idle_after, TMO + 1);
        end
        xfer(32'h2000_0044, 1'b0, 32'd0, 4'd0, int'(TMO) - 1, 32'h2222_2222, 1'b0, 0, o);
        checks++;
        if ({o.lat == int'(TMO) + 1, o.rdata, o.err} !== {1'b1, 32'h2222_2222, 1'b0}) begin
            errors++; $display("FAIL timeout_pready_priority: got lat=%0d rd=%h err=%b expected %0d 22222222 0",
                o.lat, o.rdata, o.err, TMO + 1);
        end
`else
        xfer(32'h2000_0040, 1'b0, 32'd0, 4'd0, 20, 32'h3333_3333, 1'b0, 0, o);
        checks++;
        if ({o.lat == 22, o.stable, o.rdata, o.err} !== {1'b1, 1'b1, 32'h3333_3333, 1'b0}) begin
            errors++; $display("FAIL no_timeout_wait: got lat=%0d stable=%b rd=%h err=%b expected 22 1 33333333 0",
                o.lat, o.stable, o.rdata, o.err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   t_prev;
        xfer(32'h2000_0100, 1'b1, 32'h0000_0001, 4'h1, 0, 32'd0, 1'b0, 0, o);
        t_prev = o.t_acc;
        for (int i = 0; i < 3; i++) begin
            xfer(32'h2000_0104 + 32'(i * 4), 1'b0, 32'd0, 4'd0, 0, 32'h7000_0000 + 32'(i), 1'b0, 0, o);
            checks++;
            if ((o.t_acc - t_prev) != 4 || o.rdata !== 32'h7000_0000 + 32'(i)) begin
                errors++; $display("FAIL back_to_back_%0d: got spacing=%0d rd=%h expected 4 %h",
                    i, o.t_acc - t_prev, o.rdata, 32'h7000_0000 + 32'(i));
            end
            t_prev = o.t_acc;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic seen;
        req_valid = 1'b1; req_addr = 32'h2000_0200; req_write = 1'b0; Pready = 1'b0;
        @(posedge Pclk);
        @(negedge Pclk);
        req_valid = 1'b0;
        @(posedge Pclk);
        @(negedge Pclk);
        checks++;
        if ({Psel, Penable} !== 2'b11) begin
            errors++; $display("FAIL rstmid_in_access: got %b expected 11", {Psel, Penable});
        end
        #2 Prst = 1'b1;
        #1;
        checks++;
        if ({Psel, Penable, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async: got %b expected 000", {Psel, Penable, rsp_valid});
        end
        @(negedge Pclk);
        Prst = 1'b0;
        Pready = 1'b1; Prdata = $urandom; Pslverr = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge Pclk);
            if (rsp_valid !== 1'b0 || Psel !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_response: got spurious activity=%b expected 0", seen);
        end
        Pready = 1'b0;
        xfer(32'h2000_0204, 1'b0, 32'd0, 4'd0, 1, 32'h4444_4444, 1'b0, 0, o);
        checks++;
        if ({o.lat == 3, o.rdata, o.err, o.idle_after} !== {1'b1, 32'h4444_4444, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rstmid_recovery: got lat=%0d rd=%h err=%b idle=%b expected 3 44444444 0 1",
                o.lat, o.rdata, o.err, o.idle_after);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] addr, wd, rd, ewd, erd;
        logic [3:0]  st, est;
        logic        wr, se, eerr;
        int          wt, hold, elat;
        for (int n = 0; n < 40; n++) begin
            addr = $urandom; wr = 1'($urandom); wd = $urandom; st = 4'($urandom);
            rd = $urandom; se = ($urandom_range(0, 3) == 0);
            wt = $urandom_range(0, 6); hold = $urandom_range(0, 3);
            model(wr, wd, st, wt, rd, se, ewd, est, elat, erd, eerr);
            xfer(addr, wr, wd, st, wt, rd, se, hold, o);
            checks++;
            if ({o.rr_before, o.s_psel, o.s_pen, o.rr_setup, o.a_psel, o.a_pen, o.stable, o.resp_ok, o.idle_after} !== 9'b110011111) begin
                errors++; $display("FAIL rand%0d_protocol: got %b expected 110011111", n,
                    {o.rr_before, o.s_psel, o.s_pen, o.rr_setup, o.a_psel, o.a_pen, o.stable, o.resp_ok, o.idle_after});
            end
            checks++;
            if ({o.s_addr, o.s_write, o.s_wdata, o.s_strb} !== {addr, wr, ewd, est}) begin
                errors++; $display("FAIL rand%0d_apb: got %h %b %h %h expected %h %b %h %h", n,
                    o.s_addr, o.s_write, o.s_wdata, o.s_strb, addr, wr, ewd, est);
            end
            checks++;
            if (o.lat != elat || o.rdata !== erd || o.err !== eerr) begin
                errors++; $display("FAIL rand%0d_rsp: got lat=%0d rd=%h err=%b expected %0d %h %b", n,
                    o.lat, o.rdata, o.err, elat, erd, eerr);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Prst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_wait_states();
        test_rsp_stall();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
